// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, constants and config check for row-stationary PEs
// Contents:
//   pe_state_t  : PE job state encoding
//   STRIDE_W    : width of the runtime stride field
//   cfg_illegal : true when a (K, I, S) job cannot run on a PE of the given depths
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_I  = 3'd2,
        ST_MAC     = 3'd3,
        ST_PSUM_IN = 3'd4,
        ST_OUT     = 3'd5
    } pe_state_t;

    localparam int STRIDE_W = 2;

    function automatic logic cfg_illegal(
        input int unsigned k,
        input int unsigned i,
        input int unsigned s,
        input int unsigned max_k,
        input int unsigned max_i
    );
        return (k == 0) || (k > max_k) || (i > max_i) || (i < k) || (s == 0);
    endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - signed multiply-accumulate with clear and external-add controls
// Ports:
//   i_clk, i_rst    : clock, async active-high reset
//   i_clear         : zero the accumulator (highest priority)
//   i_en            : acc += i_a * i_b
//   i_add_ext       : acc += i_ext
//   i_a, i_b        : signed operands
//   i_ext           : signed addend in accumulator width
//   o_acc           : accumulator value
module pe_mac #(
    parameter int D_WIDTH   = 32,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic                        i_add_ext,
    input  logic signed [D_WIDTH-1:0]   i_a,
    input  logic signed [D_WIDTH-1:0]   i_b,
    input  logic signed [ACC_WIDTH-1:0] i_ext,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_prod;

    // Multiplying sign-extended operands at accumulator width gives the low
    // ACC_WIDTH bits of the full product: a plain truncation when the
    // accumulator is narrower than 2*D_WIDTH, an exact sign extension otherwise.
    assign w_prod = ACC_WIDTH'(i_a) * ACC_WIDTH'(i_b);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end else if (i_add_ext) begin
            r_acc <= r_acc + i_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/pe_rs_param.sv
// rtl/pe_rs_param.sv - parametrised row-stationary PE: 1-D convolution with runtime K/I/S
// Ports:
//   clk, rst                         : clock, async active-high reset
//   start, kernel_size, iact_size,
//   stride, keep_weight, use_psum_in : job request and config, latched on start in IDLE
//   w_*                              : weight stream (K words unless keep_weight)
//   i_*                              : input-activation stream (I words)
//   psum_in*                         : neighbour psum stream (one per output when use_psum_in)
//   psum_out*                        : result psum stream (N = (I-K)/S + 1 words)
//   busy, done, cfg_err              : status; done and cfg_err are one-cycle pulses
module pe_rs_param
    import pe_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int ACC_WIDTH = 48,
    parameter int MAX_K     = 8,
    parameter int MAX_I     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(MAX_K+1)-1:0]   kernel_size,
    input  logic [$clog2(MAX_I+1)-1:0]   iact_size,
    input  logic [STRIDE_W-1:0]          stride,
    input  logic                         keep_weight,
    input  logic                         use_psum_in,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [D_WIDTH-1:0]           w_data,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [D_WIDTH-1:0]           i_data,
    input  logic                         psum_in_valid,
    output logic                         psum_in_ready,
    input  logic [ACC_WIDTH-1:0]         psum_in,
    output logic                         psum_out_valid,
    input  logic                         psum_out_ready,
    output logic [ACC_WIDTH-1:0]         psum_out,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int KW  = $clog2(MAX_K + 1);
    localparam int IW  = $clog2(MAX_I + 1);
    localparam int KAW = $clog2(MAX_K);
    localparam int IAW = $clog2(MAX_I);
    localparam int EW  = IW + 2;

    pe_state_t          r_state;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      r_kc;
    logic [IW-1:0]      r_i;
    logic [IW-1:0]      r_jc;
    logic [IW-1:0]      r_base;
    logic [STRIDE_W-1:0] r_s;
    logic               r_use_psum;
    logic               r_done;
    logic               r_cfg_err;
    logic [D_WIDTH-1:0] r_w_buf [MAX_K];
    logic [D_WIDTH-1:0] r_i_buf [MAX_I];

    logic               w_illegal;
    logic               w_start_ok;
    logic               w_k_last;
    logic               w_j_last;
    logic               w_out_last;
    logic               w_i_hs;
    logic               w_p_hs;
    logic               w_o_hs;
    logic               w_clear;
    logic [IAW-1:0]     w_iidx;
    logic [EW-1:0]      w_next_end;
    logic [ACC_WIDTH-1:0] w_acc;

    assign w_illegal  = cfg_illegal(32'(kernel_size), 32'(iact_size), 32'(stride),
                                    MAX_K, MAX_I);
    // A start that coincides with the done pulse belongs to the finished job.
    assign w_start_ok = (r_state == ST_IDLE) && start && !r_done;
    assign w_k_last   = (r_kc == r_k - KW'(1));
    assign w_j_last   = (r_jc == r_i - IW'(1));
    assign w_iidx     = IAW'(r_base + IW'(r_kc));
    // The current output is the last one when the next window would run past I.
    assign w_next_end = EW'(r_base) + EW'(r_s) + EW'(r_k);
    assign w_out_last = (w_next_end > EW'(r_i));

    assign w_i_hs  = (r_state == ST_LOAD_I)  && i_valid;
    assign w_p_hs  = (r_state == ST_PSUM_IN) && psum_in_valid;
    assign w_o_hs  = (r_state == ST_OUT)     && psum_out_ready;
    // Clear on every entry into MAC so each output starts from zero.
    assign w_clear = (w_i_hs && w_j_last) || w_o_hs;

    pe_mac #(
        .D_WIDTH   (D_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_clear),
        .i_en      (r_state == ST_MAC),
        .i_add_ext (w_p_hs),
        .i_a       (r_w_buf[r_kc[KAW-1:0]]),
        .i_b       (r_i_buf[w_iidx]),
        .i_ext     (psum_in),
        .o_acc     (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_kc       <= '0;
            r_i        <= '0;
            r_jc       <= '0;
            r_base     <= '0;
            r_s        <= '0;
            r_use_psum <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            for (int n = 0; n < MAX_K; n++) r_w_buf[n] <= '0;
            for (int n = 0; n < MAX_I; n++) r_i_buf[n] <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        if (w_illegal) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_k        <= kernel_size;
                            r_i        <= iact_size;
                            r_s        <= stride;
                            r_use_psum <= use_psum_in;
                            r_kc       <= '0;
                            r_jc       <= '0;
                            r_base     <= '0;
                            r_state    <= keep_weight ? ST_LOAD_I : ST_LOAD_W;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_valid) begin
                        r_w_buf[r_kc[KAW-1:0]] <= w_data;
                        if (w_k_last) begin
                            r_kc    <= '0;
                            r_state <= ST_LOAD_I;
                        end else begin
                            r_kc <= r_kc + KW'(1);
                        end
                    end
                end
                ST_LOAD_I: begin
                    if (i_valid) begin
                        r_i_buf[r_jc[IAW-1:0]] <= i_data;
                        if (w_j_last) begin
                            r_jc    <= '0;
                            r_state <= ST_MAC;
                        end else begin
                            r_jc <= r_jc + IW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (w_k_last) begin
                        r_kc    <= '0;
                        r_state <= r_use_psum ? ST_PSUM_IN : ST_OUT;
                    end else begin
                        r_kc <= r_kc + KW'(1);
                    end
                end
                ST_PSUM_IN: begin
                    if (psum_in_valid) r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (psum_out_ready) begin
                        if (w_out_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_base  <= r_base + IW'(r_s);
                            r_state <= ST_MAC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_ready        = (r_state == ST_LOAD_W);
    assign i_ready        = (r_state == ST_LOAD_I);
    assign psum_in_ready  = (r_state == ST_PSUM_IN);
    assign psum_out_valid = (r_state == ST_OUT);
    assign psum_out       = w_acc;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_pe_rs_param.sv
// tb/tb_pe_rs_param.sv - self-checking bench for pe_rs_param
module tb_pe_rs_param;

    localparam int DW = 32;
    localparam int AW = 48;
    localparam int MK = 8;
    localparam int MI = 32;
    localparam int KW = $clog2(MK + 1);
    localparam int IW = $clog2(MI + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [KW-1:0]  kernel_size = '0;
    logic [IW-1:0]  iact_size = '0;
    logic [1:0]     stride = '0;
    logic           keep_weight = 1'b0;
    logic           use_psum_in = 1'b0;
    logic           w_valid = 1'b0;
    logic           w_ready;
    logic [DW-1:0]  w_data = '0;
    logic           i_valid = 1'b0;
    logic           i_ready;
    logic [DW-1:0]  i_data = '0;
    logic           psum_in_valid = 1'b0;
    logic           psum_in_ready;
    logic [AW-1:0]  psum_in = '0;
    logic           psum_out_valid;
    logic           psum_out_ready = 1'b0;
    logic [AW-1:0]  psum_out;
    logic           busy;
    logic           done;
    logic           cfg_err;

    always #5 clk = ~clk;

    pe_rs_param #(.D_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MK), .MAX_I(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
        .iact_size(iact_size), .stride(stride), .keep_weight(keep_weight),
        .use_psum_in(use_psum_in), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
        .psum_in(psum_in), .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready), .psum_out(psum_out), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wdat[$];
    logic [DW-1:0] idat[$];
    logic [AW-1:0] pdat[$];
    logic [DW-1:0] mw[MK];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_q[$];

    int lat, wr_seen, unstable;
    bit timed_out, done_after, busy_after;

    // Reference model: expected psums pushed to the scoreboard as the job is issued.
    task automatic push_expected(input int k, input int i, input int s, input bit up);
        int n;
        logic [AW-1:0] acc;
        logic signed [2*DW-1:0] p;
        n = (i - k) / s + 1;
        for (int o = 0; o < n; o++) begin
            acc = '0;
            for (int j = 0; j < k; j++) begin
                p = $signed(mw[j]) * $signed(idat[o*s+j]);
                acc = acc + p[AW-1:0];
            end
            if (up) acc = acc + pdat[o];
            exp_q.push_back(acc);
        end
    endtask

    // Issues one job, feeds streams (optionally with random stalls), captures
    // psum_out handshakes into got_q, and records timing/monitor results.
    task automatic run_job(input int k, input int i, input int s, input bit kw,
                           input bit up, input bit stall, input int hold, input bit sad);
        int wi, ii, pi, vcnt;
        bit hv, wh, ih, ph, oh, ov;
        logic [AW-1:0] held, cur;
        wi = 0; ii = 0; pi = 0; vcnt = 0; hv = 0; held = '0;
        lat = 0; wr_seen = 0; unstable = 0; timed_out = 1; done_after = 0; busy_after = 0;
        if (!kw) for (int j = 0; j < k; j++) mw[j] = wdat[j];
        push_expected(k, i, s, up);
        @(negedge clk);
        kernel_size = KW'(k); iact_size = IW'(i); stride = 2'(s);
        keep_weight = kw; use_psum_in = up; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            w_valid = (wi < k) && !kw && (!stall || $urandom_range(0, 1) == 1);
            w_data  = (wi < wdat.size()) ? wdat[wi] : '0;
            i_valid = (ii < i) && (!stall || $urandom_range(0, 1) == 1);
            i_data  = (ii < idat.size()) ? idat[ii] : '0;
            psum_in_valid = up && (pi < pdat.size()) && (!stall || $urandom_range(0, 1) == 1);
            psum_in = (pi < pdat.size()) ? pdat[pi] : '0;
            psum_out_ready = (vcnt >= hold) && (!stall || $urandom_range(0, 1) == 1);
            #1;
            if (w_ready) wr_seen++;
            wh = w_valid && w_ready;
            ih = i_valid && i_ready;
            ph = psum_in_valid && psum_in_ready;
            ov = psum_out_valid;
            oh = psum_out_valid && psum_out_ready;
            cur = psum_out;
            if (ov) begin
                if (hv && cur !== held) unstable++;
                vcnt++;
            end
            @(posedge clk);
            if (wh) wi++;
            if (ih) ii++;
            if (ph) pi++;
            if (oh) begin
                got_q.push_back(cur);
                hv = 0;
            end else if (ov) begin
                hv = 1;
                held = cur;
            end
            #1;
            if (done) begin
                lat = cyc + 2;
                timed_out = 0;
                break;
            end
        end
        start = sad;
        w_valid = 0; i_valid = 0; psum_in_valid = 0; psum_out_ready = 0;
        @(posedge clk);
        #1;
        busy_after = busy;
        done_after = done;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({w_ready, i_ready, psum_in_ready, psum_out_valid, busy, done, cfg_err} !== 7'b0 ||
            psum_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b psum=%0d exp 0",
                     {w_ready, i_ready, psum_in_ready, psum_out_valid, busy, done, cfg_err}, psum_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_stride1;
        logic [AW-1:0] e, g;
        wdat = {32'd2, 32'd3, 32'd4};
        idat = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        pdat.delete();
        run_job(3, 5, 1, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL s1_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL s1_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (lat != 3 + 5 + 3 * (3 + 1) + 1) begin
            errors++;
            $display("FAIL s1_latency got %0d exp %0d", lat, 3 + 5 + 3 * 4 + 1);
        end
        checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL s1_done_pulse got done=%b busy=%b exp 0 0", done_after, busy_after);
        end
    endtask

    task automatic test_stride2;
        logic [AW-1:0] e, g;
        run_job(3, 5, 2, 0, 0, 0, 0, 1);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL s2_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL s2_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (lat != 3 + 5 + 2 * (3 + 1) + 1) begin
            errors++;
            $display("FAIL s2_latency got %0d exp %0d", lat, 3 + 5 + 2 * 4 + 1);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            errors++;
            $display("FAIL start_at_done busy got %b exp 0", busy_after);
        end
    endtask

    task automatic test_psum_in;
        logic [AW-1:0] e, g;
        pdat = {48'd100, 48'd200, 48'd300};
        run_job(3, 5, 1, 0, 1, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pin_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL pin_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (lat != 3 + 5 + 3 * (3 + 1 + 1) + 1) begin
            errors++;
            $display("FAIL pin_latency got %0d exp %0d", lat, 3 + 5 + 3 * 5 + 1);
        end
    endtask

    task automatic test_keep_weight;
        logic [AW-1:0] e, g;
        wdat = {32'd99, 32'd99, 32'd99};
        idat = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        pdat.delete();
        run_job(3, 5, 1, 1, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL kw_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL kw_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL kw_no_wready got %0d cycles exp 0", wr_seen);
        end
        checks++;
        if (lat != 5 + 3 * (3 + 1) + 1) begin
            errors++;
            $display("FAIL kw_latency got %0d exp %0d", lat, 5 + 3 * 4 + 1);
        end
    endtask

    task automatic test_stalls;
        logic [AW-1:0] e, g;
        wdat = {32'd2, 32'd3, 32'd4};
        idat = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        pdat = {48'd100, 48'd200, 48'd300};
        run_job(3, 5, 1, 0, 1, 1, 10, 0);
        // Random signed data exercises product truncation and wrap.
        wdat.delete(); idat.delete(); pdat.delete();
        for (int n = 0; n < 4; n++) wdat.push_back($urandom);
        for (int n = 0; n < 11; n++) idat.push_back($urandom);
        for (int n = 0; n < 3; n++) pdat.push_back(AW'({$urandom, $urandom}));
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL stall_stable got %0d changes exp 0", unstable);
        end
        run_job(4, 11, 3, 0, 1, 1, 0, 0);
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL stall_rand_stable got %0d changes exp 0", unstable);
        end
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL stall_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_boundary;
        logic [AW-1:0] e, g;
        wdat.delete(); idat.delete(); pdat.delete();
        for (int n = 0; n < MK; n++) wdat.push_back($urandom);
        for (int n = 0; n < MI; n++) idat.push_back($urandom);
        run_job(MK, MI, 3, 0, 0, 0, 0, 0);
        run_job(4, 4, 2, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bnd_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL bnd_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_cfg_err;
        int cfg[5][3] = '{'{4, 3, 1}, '{0, 5, 1}, '{3, 5, 0}, '{9, 20, 1}, '{3, 33, 1}};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            kernel_size = KW'(cfg[n][0]); iact_size = IW'(cfg[n][1]); stride = 2'(cfg[n][2]);
            keep_weight = 0; use_psum_in = 0; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_%0d got err=%b busy=%b exp 1 0", n, cfg_err, busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL cfg_pulse_%0d got err=%b busy=%b done=%b exp 0 0 0", n, cfg_err, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        logic [AW-1:0] e, g;
        @(negedge clk);
        kernel_size = KW'(3); iact_size = IW'(5); stride = 2'd1;
        keep_weight = 0; use_psum_in = 0; start = 1'b1;
        w_valid = 1; w_data = 32'd7; i_valid = 1; i_data = 32'd9; psum_out_ready = 1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({w_ready, i_ready, psum_in_ready, psum_out_valid, busy, done, cfg_err} !== 7'b0 ||
            psum_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got flags=%b psum=%0d exp 0",
                     {w_ready, i_ready, psum_in_ready, psum_out_valid, busy, done, cfg_err}, psum_out);
        end
        @(negedge clk);
        rst = 1'b0;
        w_valid = 0; i_valid = 0;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done || psum_out_valid || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles exp 0", bad);
        end
        psum_out_ready = 0;
        // Reset clears the weight scratchpad, so a weight-reuse job yields zeros.
        for (int j = 0; j < MK; j++) mw[j] = '0;
        idat = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        pdat.delete();
        run_job(3, 5, 1, 1, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_kw_count got %0d timeout=%0d exp %0d", got_q.size(), timed_out, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL rst_kw_psum got %0d exp %0d", $signed(g), $signed(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        for (int j = 0; j < MK; j++) mw[j] = '0;
        test_reset();
        test_stride1();
        test_stride2();
        test_psum_in();
        test_keep_weight();
        test_stalls();
        test_boundary();
        test_cfg_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
